// File: rtl/mips_mem_pkg.sv
// Shared types for the multi-cycle MIPS memory responder.
package mips_mem_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} memstate_t;
endpackage

// File: rtl/mips_mem_responder_if.sv
// Request/response bus between the MIPS datapath (master) and the memory responder (slave).
interface mips_mem_responder_if;
  import mips_mem_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input ready, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/mips_mem_array.sv
// Synchronous single-port word RAM; read data register only updates on enabled reads.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[idx] <= wdata;
      else    rdata_q    <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mips_mem_responder.sv
// Fixed-latency memory responder for the multi-cycle MIPS core (IDLE/WAIT/ACCESS/RESP).
// Optional alignment checking is enabled by defining MIPS_MEM_ALIGN_CHECK_EN.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input logic                 clk,
  input logic                 reset,
  mips_mem_responder_if.slave bus
);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  memstate_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              rd_sel_q, rd_sel_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] ram_rdata;
  logic              req_mis;
  logic              ram_en;
  logic              unused_addr;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
  assign req_mis = (bus.addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // Upper address bits wrap silently; byte offset only matters for the alignment check.
  assign unused_addr = ^{bus.addr[WORD_W-1:AW+2], bus.addr[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rd_sel_d = rd_sel_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    mis_d    = mis_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = bus.addr[AW+1:2];
          wdata_d = bus.wdata;
          mis_d   = req_mis;
          cnt_d   = CNT_W'(LATENCY - 1);
          ready_d = 1'b0;
          if (LATENCY == 1) state_d = ACCESS;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        err_d    = mis_q;
        // rdata shows the RAM read register after an aligned read, zero after an error.
        if (mis_q)      rd_sel_d = 1'b0;
        else if (!we_q) rd_sel_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        cnt_d    = '0;
        rd_sel_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    mis_q   <= mis_d;
  end

  // A reset during WAIT/ACCESS leaves state_q in IDLE, so the pending write never fires.
  assign ram_en = (state_q == ACCESS) && !mis_q;

  mips_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rd_sel_q ? ram_rdata : '0;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed scoreboard bench for mips_mem_responder (DEPTH_WORDS=64, LATENCY=2).
module tb_mips_mem_responder;
  localparam int DEPTH   = 64;
  localparam int LAT     = 2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   total_cnt;
  int   pass_cnt;
  int   fail_cnt;
  exp_t exp_q [$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rd;

  mips_mem_responder_if bus ();

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response is matched against the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", bus.rdata, e.rd);
        chk("resp_err", {31'd0, bus.err}, {31'd0, e.err});
      end
    end
  end

  function automatic exp_t model_txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic mis;
    int   idx;
    idx = int'(a[31:2]) % DEPTH;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    e.err = mis;
    if (mis) begin
      last_rd = 32'd0;
    end else if (w) begin
      model_mem[idx] = d;
    end else begin
      last_rd = model_mem[idx];
    end
    e.rd = last_rd;
    return e;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    wait_ready();
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    exp_q.push_back(model_txn(w, a, d));
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    chk("ready_low_after_accept", {31'd0, bus.ready}, 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      chk("ready_low_in_flight", {31'd0, bus.ready}, 32'd0);
    end while (bus.rvalid !== 1'b1 && n < 20);
    chk("latency_edges", n, LAT + 1);
  endtask

  initial begin
    int   acc;
    int   rvcnt;
    logic prev_ready;
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    last_rd   = 32'd0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    reset     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);

    // Store then read back
    txn(1'b1, 32'h10, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_held_idle", bus.rdata, 32'hDEADBEEF);

    // req held high: one transaction per IDLE visit
    @(negedge clk);
    wait_ready();
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h10;
    exp_q.push_back(model_txn(1'b0, 32'h10, 32'h0));
    exp_q.push_back(model_txn(1'b0, 32'h10, 32'h0));
    acc = 0;
    rvcnt = 0;
    prev_ready = bus.ready;
    for (int k = 0; k < 40 && rvcnt < 2; k++) begin
      if (prev_ready && bus.req) acc++;
      @(posedge clk);
      #1;
      if (bus.rvalid === 1'b1) rvcnt++;
      if (acc > rvcnt || bus.rvalid === 1'b1)
        chk("held_req_ready_low", {31'd0, bus.ready}, 32'd0);
      prev_ready = bus.ready;
    end
    bus.req = 1'b0;
    chk("held_req_accepts", acc, 2);
    chk("held_req_responses", rvcnt, 2);

    // Address wrap: 0x100 aliases word 0
    txn(1'b1, 32'h100, 32'h1234);
    txn(1'b0, 32'h000, 32'h0);
    chk("wrap_rdata", bus.rdata, 32'h00001234);

    // Reset during WAIT of a store drops it
    txn(1'b1, 32'h20, 32'h11112222);
    @(negedge clk);
    wait_ready();
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h20;
    bus.wdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    reset   = 1'b0;
    last_rd = 32'd0;
    #1;
    chk("abort_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("abort_rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_rvalid", {31'd0, bus.rvalid}, 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0);
    chk("abort_prior_kept", bus.rdata, 32'h11112222);

    // Misaligned store and the following read of the same word
    txn(1'b1, 32'h22, 32'h5A5A0001);
    txn(1'b0, 32'h20, 32'h0);
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    chk("misaligned_word_unchanged", bus.rdata, 32'h11112222);
`else
    chk("unaligned_store_written", bus.rdata, 32'h5A5A0001);
`endif

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
